// File: rtl/hash_job_sequencer.sv
// Job sequencer: RECIEVING -> HASHING -> SENDING, with abort, job counter and done pulse.
// Define HASH_SEQ_TIMEOUT_EN to add the SENDING watchdog and sticky ERROR state.
module hash_job_sequencer #(
  parameter int unsigned TICK_W         = 8,
  parameter int unsigned JOB_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              finished_recieving,
  input  logic              finished_sending,
  input  logic              second_tick,
  input  logic              abort,
  input  logic [TICK_W-1:0] cfg_hash_ticks,
  output logic              read_enable,
  output logic              hash_enable,
  output logic              write_enable,
  output logic              job_done,
  output logic [JOB_W-1:0]  job_count,
  output logic              error
);

  typedef enum logic [1:0] {
    RECIEVING = 2'd0,
    HASHING   = 2'd1,
    SENDING   = 2'd2,
    ERROR     = 2'd3
  } state_t;

  // Elaboration-time guard on the watchdog period
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("hash_job_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [JOB_W-1:0]   count_d;
  logic               done_d;

`ifdef HASH_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0]    wd_q, wd_d;
`endif

  // Next-state, counter and pulse logic; abort overrides every normal transition
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    count_d = job_count;
    done_d  = 1'b0;
`ifdef HASH_SEQ_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    if (abort) begin
      state_d = RECIEVING;
      tick_d  = '0;
`ifdef HASH_SEQ_TIMEOUT_EN
      wd_d    = '0;
`endif
    end else begin
      case (state_q)
        RECIEVING: begin
          if (finished_recieving) begin
            state_d = HASHING;
            tick_d  = (cfg_hash_ticks == '0) ? TICK_W'(1) : cfg_hash_ticks;
          end
        end
        HASHING: begin
          if (second_tick) begin
            tick_d = tick_q - TICK_W'(1);
            if (tick_q <= TICK_W'(1)) begin
              state_d = SENDING;
              tick_d  = '0;
`ifdef HASH_SEQ_TIMEOUT_EN
              wd_d    = '0;
`endif
            end
          end
        end
        SENDING: begin
          if (finished_sending) begin
            state_d = RECIEVING;
            count_d = job_count + JOB_W'(1);
            done_d  = 1'b1;
`ifdef HASH_SEQ_TIMEOUT_EN
            wd_d    = '0;
          end else if (wd_q == WD_LAST) begin
            state_d = ERROR;
            wd_d    = '0;
          end else begin
            wd_d    = wd_q + WD_W'(1);
`endif
          end
        end
`ifdef HASH_SEQ_TIMEOUT_EN
        ERROR: begin
          state_d = ERROR;
        end
`endif
        default: begin
          state_d = RECIEVING;
          tick_d  = '0;
        end
      endcase
    end
  end

  // State, counters and registered Moore outputs
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= RECIEVING;
      tick_q       <= '0;
      job_count    <= '0;
      job_done     <= 1'b0;
      read_enable  <= 1'b1;
      hash_enable  <= 1'b0;
      write_enable <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      job_count    <= count_d;
      job_done     <= done_d;
      read_enable  <= (state_d == RECIEVING);
      hash_enable  <= (state_d == HASHING);
      write_enable <= (state_d == SENDING);
    end
  end

`ifdef HASH_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      wd_q  <= '0;
      error <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      error <= (state_d == ERROR);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_hash_job_sequencer.sv
// Self-checking bench for hash_job_sequencer; completions are scoreboarded against job_done pulses.
module tb_hash_job_sequencer;

  localparam int unsigned TICK_W         = 8;
  localparam int unsigned JOB_W          = 2;
  localparam int unsigned TIMEOUT_CYCLES = 8;
  localparam int          COUNT_MOD      = 1 << JOB_W;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              finished_recieving;
  logic              finished_sending;
  logic              second_tick;
  logic              abort;
  logic [TICK_W-1:0] cfg_hash_ticks;
  logic              read_enable;
  logic              hash_enable;
  logic              write_enable;
  logic              job_done;
  logic [JOB_W-1:0]  job_count;
  logic              error;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_done    = 0;
  int n_pushed  = 0;
  int exp_count = 0;
  int sb_q[$];

  hash_job_sequencer #(
    .TICK_W(TICK_W),
    .JOB_W(JOB_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_i(rst_i),
    .finished_recieving(finished_recieving),
    .finished_sending(finished_sending),
    .second_tick(second_tick),
    .abort(abort),
    .cfg_hash_ticks(cfg_hash_ticks),
    .read_enable(read_enable),
    .hash_enable(hash_enable),
    .write_enable(write_enable),
    .job_done(job_done),
    .job_count(job_count),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Each job_done pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (rst_i === 1'b1 && job_done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        check("sb_job_count", 32'(job_count), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_en(input string tag, input logic [2:0] e);
    check(tag, 32'({read_enable, hash_enable, write_enable}), 32'(e));
  endtask

  task automatic chk_out(input string tag, input logic d, input int cnt);
    check({tag, "_done"}, 32'(job_done), 32'(d));
    check({tag, "_cnt"}, 32'(job_count), cnt);
  endtask

  task automatic enter_hash(input int c, input logic coinc_tick);
    cfg_hash_ticks     = TICK_W'(c);
    finished_recieving = 1'b1;
    second_tick        = coinc_tick;
    step();
    finished_recieving = 1'b0;
    second_tick        = 1'b0;
    chk_en("hash_entry", 3'b010);
  endtask

  task automatic hash_ticks(input int n);
    for (int i = 1; i <= n; i++) begin
      second_tick = 1'b1;
      step();
      second_tick = 1'b0;
      if (i < n) begin
        chk_en("hashing", 3'b010);
        step();
        chk_en("hash_idle", 3'b010);
      end else begin
        chk_en("send_entry", 3'b001);
      end
    end
  endtask

  task automatic expect_completion();
    exp_count = (exp_count + 1) % COUNT_MOD;
    sb_q.push_back(exp_count);
    n_pushed++;
  endtask

  task automatic finish_job();
    finished_sending = 1'b1;
    expect_completion();
    step();
    finished_sending = 1'b0;
    chk_en("send_done", 3'b100);
    chk_out("complete", 1'b1, exp_count);
    step();
    chk_out("done_pulse_end", 1'b0, exp_count);
    chk_en("recv_idle", 3'b100);
  endtask

  initial begin
    int wrap_seq[5];
    wrap_seq = '{1, 2, 3, 0, 1};

    rst_i              = 1'b0;
    finished_recieving = 1'b0;
    finished_sending   = 1'b0;
    second_tick        = 1'b0;
    abort              = 1'b0;
    cfg_hash_ticks     = TICK_W'(3);

    // Reset state
    #12;
    chk_en("reset", 3'b100);
    chk_out("reset", 1'b0, 0);
    check("reset_error", 32'(error), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    step();
    chk_en("post_reset", 3'b100);

    // Default path with three ticks
    enter_hash(3, 1'b0);
    hash_ticks(3);
    finish_job();

    // cfg=0 and cfg=1 with a tick coincident with entry
    enter_hash(0, 1'b1);
    step();
    chk_en("zero_cfg_wait", 3'b010);
    hash_ticks(1);
    finish_job();
    enter_hash(1, 1'b1);
    hash_ticks(1);
    finish_job();

    // cfg changes mid-HASHING are ignored
    enter_hash(2, 1'b0);
    cfg_hash_ticks = TICK_W'(1);
    hash_ticks(2);
    finish_job();

    // Abort in HASHING after 1 of 4 ticks
    enter_hash(4, 1'b0);
    second_tick = 1'b1;
    step();
    second_tick = 1'b0;
    chk_en("abort_pre", 3'b010);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_en("abort_hash", 3'b100);
    chk_out("abort_hash", 1'b0, exp_count);

    // Abort beats finished_recieving in RECIEVING
    abort              = 1'b1;
    finished_recieving = 1'b1;
    step();
    abort              = 1'b0;
    finished_recieving = 1'b0;
    chk_en("abort_recv", 3'b100);

    // Abort coincident with finished_sending
    enter_hash(2, 1'b0);
    hash_ticks(2);
    abort            = 1'b1;
    finished_sending = 1'b1;
    step();
    abort            = 1'b0;
    finished_sending = 1'b0;
    chk_en("abort_send", 3'b100);
    chk_out("abort_send", 1'b0, exp_count);
    step();
    chk_out("abort_send_after", 1'b0, exp_count);

    enter_hash(1, 1'b0);
    hash_ticks(1);
    finish_job();

    // Async reset between edges while in SENDING
    enter_hash(1, 1'b0);
    hash_ticks(1);
    #2;
    rst_i = 1'b0;
    #1;
    chk_en("async_rst", 3'b100);
    chk_out("async_rst", 1'b0, 0);
    check("async_rst_error", 32'(error), 32'd0);
    exp_count = 0;
    @(negedge clk);
    rst_i = 1'b1;
    step();
    chk_en("async_rst_release", 3'b100);

    // Counter wrap over five jobs
    for (int j = 0; j < 5; j++) begin
      enter_hash((j % 3) + 1, 1'b0);
      hash_ticks((j % 3) + 1);
      finish_job();
      check("wrap_seq", 32'(job_count), 32'(wrap_seq[j]));
    end

    // Back-to-back: finished_recieving already high on re-entry
    enter_hash(1, 1'b0);
    hash_ticks(1);
    cfg_hash_ticks     = TICK_W'(2);
    finished_sending   = 1'b1;
    finished_recieving = 1'b1;
    expect_completion();
    step();
    finished_sending = 1'b0;
    chk_en("b2b_recv", 3'b100);
    chk_out("b2b_recv", 1'b1, exp_count);
    step();
    finished_recieving = 1'b0;
    chk_en("b2b_hash", 3'b010);
    chk_out("b2b_hash", 1'b0, exp_count);
    hash_ticks(2);
    finish_job();

`ifdef HASH_SEQ_TIMEOUT_EN
    // Watchdog expiry and sticky ERROR
    enter_hash(1, 1'b0);
    hash_ticks(1);
    for (int i = 1; i < int'(TIMEOUT_CYCLES); i++) begin
      step();
      chk_en("wd_sending", 3'b001);
      check("wd_err_low", 32'(error), 32'd0);
    end
    step();
    chk_en("wd_error", 3'b000);
    check("wd_error_flag", 32'(error), 32'd1);
    finished_recieving = 1'b1;
    finished_sending   = 1'b1;
    step();
    finished_recieving = 1'b0;
    finished_sending   = 1'b0;
    chk_en("wd_sticky", 3'b000);
    check("wd_sticky_flag", 32'(error), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_en("wd_abort", 3'b100);
    check("wd_abort_flag", 32'(error), 32'd0);
    chk_out("wd_abort", 1'b0, exp_count);

    // finished_sending on the last allowed cycle completes normally
    enter_hash(1, 1'b0);
    hash_ticks(1);
    for (int i = 1; i < int'(TIMEOUT_CYCLES); i++) begin
      step();
      chk_en("wd_edge_sending", 3'b001);
    end
    finish_job();
    check("wd_edge_flag", 32'(error), 32'd0);
`else
    check("error_tied_low", 32'(error), 32'd0);
`endif

    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("done_pulses", 32'(n_done), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_job_sequencer.md
Name: hash_job_sequencer

Overview:
- Parametrised successor to the receive/hash/send controller; sequences one job at a time through RECEIVING -> HASHING -> SENDING, then returns to RECEIVING.
- Generalisations over the previous generation:
  - runtime-programmable hash duration, counted in tick pulses
  - abort path
  - wrapping completed-job counter and per-job done pulse
  - optional SENDING watchdog with a sticky error state
- Sits between the host UART receive/transmit logic and the hash core.
- Drives the mutually exclusive read/hash/write enables.

Parameters:
- TICK_W, 8, width of cfg_hash_ticks and the internal tick down-counter.
- JOB_W, 16, width of job_count.
- TIMEOUT_CYCLES, 1000000, clock cycles allowed in SENDING before timeout (used only with the optional feature; must be >= 1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_i  in  1  asynchronous, active-low reset.
- finished_recieving  in  1  level/pulse; the receive path holds a complete job.
- finished_sending  in  1  level/pulse; the transmit path has sent the result.
- second_tick  in  1  single-cycle timebase pulse.
- abort  in  1  synchronous abort request.
- cfg_hash_ticks  in  TICK_W  number of second_tick pulses to spend in HASHING; sampled on entry to HASHING.
- read_enable  out  1  high in RECIEVING.
- hash_enable  out  1  high in HASHING.
- write_enable  out  1  high in SENDING.
- job_done  out  1  one-cycle pulse on completion of a job.
- job_count  out  JOB_W  number of completed jobs, modulo 2^JOB_W.
- error  out  1  high in ERROR; constant 0 without the optional feature.

Behaviour:
- State encoding and outputs:
  - States: RECIEVING, HASHING, SENDING, ERROR (ERROR exists only with the feature).
  - Illegal encodings return to RECIEVING on the next clock.
  - Enables and error are Moore decodes of the state register, so exactly one enable is high outside ERROR.
  - In ERROR all three enables are 0.
- Reset (rst_i=0, asynchronous):
  - state=RECIEVING, read_enable=1, hash_enable=0, write_enable=0.
  - job_done=0, job_count=0, error=0.
  - Tick counter and watchdog counter are 0.
- Priority each clock: reset > abort > normal transitions.
- Abort:
  - State goes to RECIEVING on the next edge from any state, including ERROR.
  - Tick counter and watchdog counter are cleared.
  - job_count is unchanged and job_done stays 0.
  - If finished_sending is asserted in the same cycle, abort wins: no job_done, no increment.
- RECIEVING:
  - If finished_recieving=1: go to HASHING.
  - On that same edge, load the tick counter with cfg_hash_ticks; a value of 0 is loaded as 1.
  - second_tick is ignored in RECIEVING, including when it arrives in the same cycle as finished_recieving.
- HASHING:
  - Each second_tick decrements the tick counter.
  - When second_tick=1 and the counter equals 1: go to SENDING.
  - Changes to cfg_hash_ticks mid-HASHING have no effect.
  - finished_recieving and finished_sending are ignored.
- SENDING:
  - If finished_sending=1: go to RECIEVING.
  - On that edge, job_count increments (2^JOB_W-1 wraps to 0) and job_done is registered high for exactly one cycle, coincident with read_enable rising.
- Latency: every enable changes one clock after the qualifying input is sampled.
- HASHING lasts from the entry edge until the edge sampling the Nth tick; N = max(cfg_hash_ticks, 1).
- Back-to-back jobs: if finished_recieving is already high when RECIEVING is re-entered, HASHING is entered on the next edge. RECIEVING therefore lasts a minimum of one cycle.

Optional Feature:
- Macro: HASH_SEQ_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on entry to SENDING and increments each cycle in SENDING.
  - If it reaches TIMEOUT_CYCLES without finished_sending: go to ERROR and assert error.
  - If finished_sending arrives on the same cycle the count is reached, finished_sending wins: normal completion.
  - ERROR is sticky; only abort or reset leaves it, and both go to RECIEVING.
  - job_count does not increment on a timeout.
- Undefined:
  - No watchdog counter and no ERROR state are synthesised.
  - error is tied to 0.
  - SENDING waits indefinitely.

Test Plan:
- Reset and default path:
  - Stimulus: release rst_i; cfg_hash_ticks=3; pulse finished_recieving; 3 second_tick pulses; pulse finished_sending.
  - Required: read->hash->write->read; hash_enable high until the edge after the 3rd tick; job_done 1 cycle; job_count=1.
- Zero/one ticks and ignored tick:
  - Stimulus: cfg_hash_ticks=0 with second_tick coincident with finished_recieving; repeat with cfg_hash_ticks=1.
  - Required: both runs enter SENDING on the first tick sampled in HASHING, not on the coincident tick.
- Abort mid-operation:
  - Stimulus: abort in HASHING after 1 of 4 ticks; separately, abort coincident with finished_sending.
  - Required: both return to RECIEVING; job_count unchanged; job_done=0.
- Wrap:
  - Stimulus: JOB_W=2; run 5 complete jobs.
  - Required: job_count sequence 1,2,3,0,1; five job_done pulses.
- Async reset mid-SENDING:
  - Stimulus: drop rst_i between clock edges.
  - Required: outputs reach reset values immediately; job_count=0.
- Watchdog (HASH_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: no finished_sending.
  - Required: ERROR after 8 cycles in SENDING; all enables 0 and error=1; abort returns to RECIEVING.
  - Stimulus: finished_sending exactly on cycle 8.
  - Required: normal completion, job_count increments.
